// File: rtl/alu_step_sequencer.sv
// alu_step_sequencer: holds a small loadable program and, on each step press
// or run-mode tick, fetches one instruction and presents its decoded fields
// to the ALU/register-file datapath, followed by a one-cycle exec strobe.
module alu_step_sequencer #(
    parameter int          DEPTH   = 16,
    parameter int          RUN_DIV = 25_000_000,
    parameter logic [3:0]  HALT_OP = 4'hF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       step,
    input  logic                       run,
    input  logic                       restart,
    input  logic                       load_we,
    input  logic [$clog2(DEPTH)-1:0]   load_addr,
    input  logic [29:0]                load_data,
    output logic [2:0]                 a_reg,
    output logic [2:0]                 b_reg,
    output logic [2:0]                 dest_reg,
    output logic [3:0]                 alu_op,
    output logic [15:0]                immediate,
    output logic                       immediate_p,
    output logic                       exec,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic                       halted
);

    localparam int PC_W  = $clog2(DEPTH);
    localparam int CNT_W = $clog2(RUN_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RUN_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic              step_meta_q, step_meta_d;
    logic              step_sync_q, step_sync_d;
    logic              step_prev_q, step_prev_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [29:0]       field_q, field_d;
    logic              halt_seen_q, halt_seen_d;
    logic [29:0]       mem [DEPTH];
    logic [29:0]       rd_word;
    logic              req;

    // Program memory: writes land in any state and are never reset, so the
    // program survives a reset and can be loaded while reset is held.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    // Next-state logic: synchronizer, run-mode divider, sequencing FSM.
    always_comb begin
        state_d     = state_q;
        step_meta_d = step;
        step_sync_d = step_meta_q;
        step_prev_d = step_sync_q;
        pc_d        = pc_q;
        field_d     = field_q;
        halt_seen_d = halt_seen_q;
        rd_word     = mem[pc_q];

        // The tick fires when the divider counts down into zero, so the reset
        // value of zero reloads the divider instead of producing an early step.
        if (!run || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        tick_d = run && (cnt_q == CNT_W'(1));

        req = (!run && step_sync_q && !step_prev_q) || (run && tick_q);

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // The read is captured straight into the field register so the
                // fields are already valid in the DECODE cycle, one cycle ahead of exec.
                halt_seen_d = (rd_word[29:26] == HALT_OP);
                if (rd_word[29:26] != HALT_OP) begin
                    field_d = rd_word;
                end
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = halt_seen_q ? S_HALT : S_ISSUE;
            end
            S_ISSUE: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Restart overrides everything, including a pending pc increment.
        if (restart) begin
            state_d     = S_IDLE;
            pc_d        = '0;
            field_d     = field_q;
            halt_seen_d = halt_seen_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
            cnt_q       <= '0;
            tick_q      <= 1'b0;
            pc_q        <= '0;
            field_q     <= '0;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_meta_q <= step_meta_d;
            step_sync_q <= step_sync_d;
            step_prev_q <= step_prev_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            pc_q        <= pc_d;
            field_q     <= field_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    assign alu_op      = field_q[29:26];
    assign dest_reg    = field_q[25:23];
    assign a_reg       = field_q[22:20];
    assign b_reg       = field_q[19:17];
    assign immediate_p = field_q[16];
    assign immediate   = field_q[15:0];
    assign exec        = (state_q == S_ISSUE) && !restart;
    assign halted      = (state_q == S_HALT);
    assign pc          = pc_q;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Testbench for alu_step_sequencer: random programs and step/restart/run
// stimulus, with expected issues queued by a reference model and checked by
// an independent monitor whenever exec is seen.
module tb_alu_step_sequencer;

    localparam int         DEPTH   = 16;
    localparam int         RUN_DIV = 8;
    localparam logic [3:0] HALT_OP = 4'hF;
    localparam int         PC_W    = 4;

    logic              clk;
    logic              reset;
    logic              step;
    logic              run;
    logic              restart;
    logic              load_we;
    logic [PC_W-1:0]   load_addr;
    logic [29:0]       load_data;
    logic [2:0]        a_reg;
    logic [2:0]        b_reg;
    logic [2:0]        dest_reg;
    logic [3:0]        alu_op;
    logic [15:0]       immediate;
    logic              immediate_p;
    logic              exec;
    logic [PC_W-1:0]   pc;
    logic              halted;
    logic [29:0]       issued;

    typedef struct {
        int          cyc;
        logic [29:0] word;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [29:0] mem_m [DEPTH];
    int          pc_m = 0;
    bit          halted_m = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    alu_step_sequencer #(
        .DEPTH   (DEPTH),
        .RUN_DIV (RUN_DIV),
        .HALT_OP (HALT_OP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .step        (step),
        .run         (run),
        .restart     (restart),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .a_reg       (a_reg),
        .b_reg       (b_reg),
        .dest_reg    (dest_reg),
        .alu_op      (alu_op),
        .immediate   (immediate),
        .immediate_p (immediate_p),
        .exec        (exec),
        .pc          (pc),
        .halted      (halted)
    );

    assign issued = {alu_op, dest_reg, a_reg, b_reg, immediate_p, immediate};

    // Free-running clock and cycle counter used to timestamp expected issues.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every exec must match the oldest queued expectation in both
    // cycle and issued word.
    always @(negedge clk) begin
        if (exec === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_exec: actual exec at cycle %0d, required none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("exec_cycle", cyc, mon_e.cyc);
                check("exec_fields", {2'b00, issued}, {2'b00, mon_e.word});
            end
        end
    end

    function automatic logic [29:0] rand_word(input bit allow_halt);
        logic [3:0] op;
        if (allow_halt && $urandom_range(0, 5) == 0) begin
            op = HALT_OP;
        end else begin
            op = 4'($urandom_range(0, 14));
        end
        return {op, 26'($urandom)};
    endfunction

    task automatic load_word(input int addr, input logic [29:0] word);
        @(posedge clk); #1;
        load_we   = 1'b1;
        load_addr = PC_W'(addr);
        load_data = word;
        @(posedge clk); #1;
        load_we   = 1'b0;
        mem_m[addr] = word;
    endtask

    task automatic do_restart();
        @(posedge clk); #1;
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        repeat (2) @(posedge clk);
        pc_m     = 0;
        halted_m = 1'b0;
    endtask

    task automatic check_state(input string name);
        check({name, "_pc"}, 32'(pc), 32'(pc_m));
        check({name, "_halted"}, 32'(halted), 32'(halted_m));
    endtask

    // One step press. ev: 0 plain, 1 restart in ISSUE, 2 overwrite the
    // fetched word during FETCH, 3 async reset during DECODE.
    task automatic do_step(input int ev, input logic [29:0] new_word);
        int          c;
        int          pc0;
        logic [29:0] w;
        @(posedge clk); #1;
        c    = cyc;
        step = 1'b1;
        pc0  = pc_m;
        w    = mem_m[pc_m];
        if (!halted_m) begin
            if (w[29:26] == HALT_OP) begin
                halted_m = 1'b1;
            end else if (ev == 1 || ev == 3) begin
                pc_m = 0;
            end else begin
                exp_q.push_back('{c + 5, w});
                pc_m = (pc_m + 1) % DEPTH;
            end
        end
        if (ev == 2) begin
            mem_m[pc0] = new_word;
        end
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                step = 1'b0;
                if (ev == 2) begin
                    load_we   = 1'b1;
                    load_addr = PC_W'(pc0);
                    load_data = new_word;
                end
            end
            if (k == 4) begin
                load_we = 1'b0;
                if (ev == 3) begin
                    reset = 1'b0;
                    #1;
                    check("async_rst_exec", 32'(exec), 32'd0);
                    check("async_rst_fields", {2'b00, issued}, 32'd0);
                    check("async_rst_pc", 32'(pc), 32'd0);
                end
            end
            if (k == 5 && ev == 1) begin
                restart = 1'b1;
            end
            if (k == 6) begin
                restart = 1'b0;
                reset   = 1'b1;
            end
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int          c0;
        logic [29:0] w_new;
        reset     = 1'b0;
        run       = 1'b1;
        step      = 1'b0;
        restart   = 1'b0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        // Program loaded while reset is held in run mode.
        repeat (2) @(posedge clk);
        load_word(0, {4'h0, 3'd2, 3'd0, 3'd1, 1'b0, 16'h0000});
        load_word(1, {4'h1, 3'd3, 3'd2, 3'd0, 1'b1, 16'h0005});
        load_word(2, {HALT_OP, 3'd5, 3'd1, 3'd4, 1'b1, 16'h1234});
        for (int i = 3; i < DEPTH; i++) load_word(i, rand_word(1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("rst_exec", 32'(exec), 32'd0);
        check("rst_fields", {2'b00, issued}, 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // Run mode: first tick RUN_DIV cycles after release, exec 3 later.
        @(posedge clk); #1;
        c0    = cyc;
        reset = 1'b1;
        exp_q.push_back('{c0 + RUN_DIV + 3, mem_m[0]});
        exp_q.push_back('{c0 + 2 * RUN_DIV + 3, mem_m[1]});
        pc_m = 2;
        repeat (20) @(posedge clk);
        #1;
        run = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_state("run_mode");

        // Single step through ADD, SUB, then HALT.
        do_restart();
        check_state("restart1");
        do_step(0, '0);
        check_state("step1");
        do_step(0, '0);
        check_state("step2");
        do_step(0, '0);
        check_state("halt");
        do_step(0, '0);
        check_state("halt_ignored");
        do_restart();
        check_state("halt_restart");

        // Wrap: all entries non-halt, 17 steps.
        for (int i = 0; i < DEPTH; i++) load_word(i, rand_word(1'b0));
        for (int i = 0; i < DEPTH; i++) do_step(0, '0);
        check_state("wrap");
        do_step(0, '0);
        check_state("wrap_reissue");

        // Collisions.
        do_step(1, '0);
        check_state("restart_in_issue");
        w_new = rand_word(1'b0);
        do_step(2, w_new);
        check_state("write_in_fetch");
        do_restart();
        do_step(0, '0);
        check_state("write_next_pass");

        // Async reset mid-operation, then fetch from addr 0.
        do_step(3, '0);
        check_state("async_rst");
        do_step(0, '0);
        check_state("after_async_rst");

        // Random programs with halts, steps and restarts.
        for (int i = 0; i < DEPTH; i++) load_word(i, rand_word(1'b1));
        do_restart();
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_restart();
            end else begin
                do_step(0, '0);
            end
            check_state("random");
        end

        repeat (10) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
